// File: rtl/blockade_pkg.sv
// blockade_pkg: shared FSM states, ioctl indices, config addresses and game modes
package blockade_pkg;
    typedef enum logic [2:0] {BOOT, LOAD, DRAIN, HOLD, RUN} state_t;
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_CFG = 8'd1;
    localparam logic [24:0] CFG_ADDR_MODE = 25'd0;
    localparam logic [24:0] CFG_ADDR_OVERLAY = 25'd1;
    localparam logic [1:0] GM_BLOCKADE = 2'd0;
    localparam logic [1:0] GM_COMOTION = 2'd1;
    localparam logic [1:0] GM_HUSTLE = 2'd2;
    localparam logic [1:0] GM_BLASTO = 2'd3;
endpackage

// File: rtl/blockade_loader_wr.sv
// blockade_loader_wr: ROM write pulse engine with a 1-deep skid buffer and HPS wait
module blockade_loader_wr #(
    parameter int WR_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [13:0] i_addr,
    input  logic [7:0]  i_data,
    output logic [13:0] o_dn_addr,
    output logic [7:0]  o_dn_data,
    output logic        o_dn_wr,
    output logic        o_wait,
    output logic        o_loaded,
    output logic        o_error,
    output logic        o_idle
);
    localparam int CW = $clog2(WR_CYCLES) + 1;
    logic [CW-1:0] r_cnt;
    logic          r_buf_v;
    logic [13:0]   r_buf_addr;
    logic [7:0]    r_buf_data;
    logic          w_free, w_take_buf, w_take_stb, w_buf_v_next;
    // The engine is free when idle or on the last cycle of a pulse; the buffer always has priority
    always_comb begin
        w_free       = !o_dn_wr || r_cnt == '0;
        w_take_buf   = w_free && r_buf_v;
        w_take_stb   = i_stb && !o_dn_wr && !r_buf_v;
        w_buf_v_next = r_buf_v ? !w_free : (i_stb && o_dn_wr);
        o_idle       = !o_dn_wr && !r_buf_v;
    end
    // Pulse engine, buffer capture, sticky flags; wait covers buffer-full cycles plus the drain cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_buf_v    <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            o_dn_addr  <= '0;
            o_dn_data  <= '0;
            o_dn_wr    <= 1'b0;
            o_wait     <= 1'b0;
            o_loaded   <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            r_buf_v <= w_buf_v_next;
            o_wait  <= w_buf_v_next || r_buf_v;
            if (i_stb && o_dn_wr && !r_buf_v) begin
                r_buf_addr <= i_addr;
                r_buf_data <= i_data;
            end
            if (i_stb && r_buf_v)
                o_error <= 1'b1;
            if (w_take_buf || w_take_stb) begin
                o_dn_wr   <= 1'b1;
                r_cnt     <= CW'(WR_CYCLES - 1);
                o_dn_addr <= w_take_buf ? r_buf_addr : i_addr;
                o_dn_data <= w_take_buf ? r_buf_data : i_data;
                o_loaded  <= 1'b1;
            end else if (o_dn_wr) begin
                if (r_cnt == '0)
                    o_dn_wr <= 1'b0;
                else
                    r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/blockade_loader.sv
// blockade_loader: ioctl download sequencer, config latches and core reset owner
module blockade_loader
    import blockade_pkg::*;
#(
    parameter int ROM_SIZE      = 16384,
    parameter int WR_CYCLES     = 2,
    parameter int RESET_STRETCH = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_user_reset,
    input  logic        i_ioctl_download,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    input  logic [7:0]  i_ioctl_index,
    output logic        o_ioctl_wait,
    output logic [13:0] o_dn_addr,
    output logic [7:0]  o_dn_data,
    output logic        o_dn_wr,
    output logic [1:0]  o_game_mode,
    output logic [1:0]  o_overlay_type,
    output logic        o_core_reset,
    output logic        o_rom_loaded,
    output logic        o_load_error
);
    localparam int HW = $clog2(RESET_STRETCH) + 1;
    state_t        r_state, w_next;
    logic [HW-1:0] r_hold;
    logic          w_dl_ok, w_rom_stb, w_cfg_stb, w_idle;
    // Strobe qualification and next-state logic
    always_comb begin
        w_dl_ok   = i_ioctl_download && (i_ioctl_index == IDX_ROM || i_ioctl_index == IDX_CFG);
        w_rom_stb = i_ioctl_download && i_ioctl_wr && i_ioctl_index == IDX_ROM && i_ioctl_addr < 25'(ROM_SIZE);
        w_cfg_stb = i_ioctl_download && i_ioctl_wr && i_ioctl_index == IDX_CFG;
        w_next    = r_state;
        case (r_state)
            BOOT:    w_next = w_dl_ok ? LOAD : BOOT;
            LOAD:    w_next = i_ioctl_download ? LOAD : DRAIN;
            DRAIN:   w_next = w_idle ? HOLD : DRAIN;
            HOLD:    w_next = (r_hold == '0 && !i_user_reset) ? (o_rom_loaded ? RUN : BOOT) : HOLD;
            RUN:     w_next = w_dl_ok ? LOAD : (i_user_reset ? HOLD : RUN);
            default: w_next = BOOT;
        endcase
    end
    // State register, registered core reset and reset-stretch counter (preloaded outside HOLD)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= BOOT;
            o_core_reset <= 1'b1;
            r_hold       <= HW'(RESET_STRETCH - 1);
        end else begin
            r_state      <= w_next;
            o_core_reset <= w_next != RUN;
            if (r_state != HOLD || i_user_reset)
                r_hold <= HW'(RESET_STRETCH - 1);
            else if (r_hold != '0)
                r_hold <= r_hold - 1'b1;
        end
    end
    // Config bytes latch mode and overlay directly, bypassing the write engine
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_game_mode    <= GM_BLOCKADE;
            o_overlay_type <= '0;
        end else if (w_cfg_stb) begin
            if (i_ioctl_addr == CFG_ADDR_MODE)
                o_game_mode <= i_ioctl_dout[1:0];
            if (i_ioctl_addr == CFG_ADDR_OVERLAY)
                o_overlay_type <= i_ioctl_dout[1:0];
        end
    end
    blockade_loader_wr #(.WR_CYCLES(WR_CYCLES)) u_wr (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_stb    (w_rom_stb),
        .i_addr   (i_ioctl_addr[13:0]),
        .i_data   (i_ioctl_dout),
        .o_dn_addr(o_dn_addr),
        .o_dn_data(o_dn_data),
        .o_dn_wr  (o_dn_wr),
        .o_wait   (o_ioctl_wait),
        .o_loaded (o_rom_loaded),
        .o_error  (o_load_error),
        .o_idle   (w_idle)
    );
endmodule

// File: tb/tb_blockade_loader.sv
// tb_blockade_loader: scenario tasks plus a timing-arithmetic model of the ROM write stream
module tb_blockade_loader;
    localparam int ROM_SIZE = 16384;
    localparam int WR = 2;
    localparam int RS = 16;
    logic clk = 0, reset = 1, user_reset = 0, dl = 0, wr = 0;
    logic [24:0] addr = '0;
    logic [7:0] dout = '0, idx = '0;
    logic wait_o, dn_wr, core_reset, rom_loaded, load_error;
    logic [13:0] dn_addr;
    logic [7:0] dn_data;
    logic [1:0] gm, ov;
    int vectors = 0, miscompares = 0;
    typedef struct {int s; logic [13:0] a; logic [7:0] d;} pulse_t;

    blockade_loader #(.ROM_SIZE(ROM_SIZE), .WR_CYCLES(WR), .RESET_STRETCH(RS)) dut (
        .i_clk(clk), .i_reset(reset), .i_user_reset(user_reset), .i_ioctl_download(dl),
        .i_ioctl_wr(wr), .i_ioctl_addr(addr), .i_ioctl_dout(dout), .i_ioctl_index(idx),
        .o_ioctl_wait(wait_o), .o_dn_addr(dn_addr), .o_dn_data(dn_data), .o_dn_wr(dn_wr),
        .o_game_mode(gm), .o_overlay_type(ov), .o_core_reset(core_reset),
        .o_rom_loaded(rom_loaded), .o_load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; dl = 0; wr = 0; user_reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        vectors++;
        if ({core_reset, wait_o, dn_wr, rom_loaded, load_error} !== 5'b10000 ||
            dn_addr !== 14'd0 || dn_data !== 8'd0 || gm !== 2'd0 || ov !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: cr=%b wait=%b wr=%b loaded=%b err=%b addr=%h data=%h gm=%0d ov=%0d, want cr=1 others 0",
                     core_reset, wait_o, dn_wr, rom_loaded, load_error, dn_addr, dn_data, gm, ov);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            vectors++;
            if (core_reset !== 1'b1 || dn_wr !== 1'b0 || wait_o !== 1'b0) begin
                miscompares++;
                $display("FAIL boot_idle c=%0d: cr=%b wr=%b wait=%b, want 1 0 0", c, core_reset, dn_wr, wait_o);
            end
        end
    endtask

    task automatic test_config();
        @(posedge clk); #1 dl = 1; idx = 8'd1;
        @(posedge clk); #1 wr = 1; addr = 25'd0; dout = {6'($urandom), 2'b11};
        @(posedge clk); #1 addr = 25'd1; dout = {6'($urandom), 2'b10};
        @(posedge clk); #1 addr = 25'd2; dout = {6'($urandom), 2'b01};
        @(posedge clk); #1 wr = 0; dl = 0;
        @(negedge clk);
        vectors++;
        if (gm !== 2'd3 || ov !== 2'd2 || rom_loaded !== 1'b0) begin
            miscompares++;
            $display("FAIL config_latch: gm=%0d ov=%0d loaded=%b, want 3 2 0", gm, ov, rom_loaded);
        end
        for (int c = 0; c < RS + 10; c++) begin
            @(negedge clk);
            vectors++;
            if (core_reset !== 1'b1 || dn_wr !== 1'b0 || wait_o !== 1'b0 || rom_loaded !== 1'b0) begin
                miscompares++;
                $display("FAIL config_boot c=%0d: cr=%b wr=%b wait=%b loaded=%b, want 1 0 0 0", c, core_reset, dn_wr, wait_o, rom_loaded);
            end
        end
    endtask

    task automatic test_rom_spaced();
        int k;
        bit exp_wr;
        int b;
        @(posedge clk); #1 dl = 1; idx = 8'd0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            wr = (c % 4 == 0) && c < 16;
            addr = 25'(c / 4);
            dout = 8'(8'hA0 + c / 4);
            @(negedge clk);
            exp_wr = (c % 4 == 1 || c % 4 == 2) && c <= 14;
            b = (c - 1) / 4;
            vectors++;
            if (dn_wr !== exp_wr || wait_o !== 1'b0 || rom_loaded !== (c >= 1) ||
                (exp_wr && (dn_addr !== 14'(b) || dn_data !== 8'(8'hA0 + b)))) begin
                miscompares++;
                $display("FAIL rom_spaced c=%0d: wr=%b addr=%h data=%h wait=%b loaded=%b, want wr=%b addr=%h data=%h wait=0 loaded=%b",
                         c, dn_wr, dn_addr, dn_data, wait_o, rom_loaded, exp_wr, 14'(b), 8'(8'hA0 + b), c >= 1);
            end
        end
        @(posedge clk); #1 wr = 0; dl = 0;
        k = -1;
        for (int c = 0; c < RS + 20; c++) begin
            @(negedge clk);
            if (core_reset === 1'b0) begin
                k = c;
                break;
            end
        end
        vectors++;
        if (k != RS + 2) begin
            miscompares++;
            $display("FAIL stretch_release: core_reset fell after %0d cycles, want %0d", k, RS + 2);
        end
    endtask

    task automatic wait_run(input string name);
        int k;
        k = -1;
        for (int c = 0; c < RS + 20; c++) begin
            @(negedge clk);
            if (core_reset === 1'b0) begin
                k = c;
                break;
            end
        end
        vectors++;
        if (k < 0) begin
            miscompares++;
            $display("FAIL %s: core_reset still %b after %0d cycles, want 0", name, core_reset, RS + 20);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[3];
        bit exp_wr, exp_wait;
        logic [13:0] ea;
        logic [7:0] ed;
        @(posedge clk); #1 dl = 1; idx = 8'd0;
        @(negedge clk);
        vectors++;
        if (core_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL run_before_dl: cr=%b, want 0", core_reset);
        end
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            wr = c <= 2;
            addr = 25'(5 + c);
            dout = 8'($urandom);
            if (c <= 2) d[c] = dout;
            @(negedge clk);
            exp_wr = c >= 1 && c <= 4;
            exp_wait = c == 2 || c == 3;
            ea = c <= 2 ? 14'd5 : 14'd6;
            ed = c <= 2 ? d[0] : d[1];
            vectors++;
            if (core_reset !== 1'b1 || dn_wr !== exp_wr || wait_o !== exp_wait || load_error !== (c >= 3) ||
                (exp_wr && (dn_addr !== ea || dn_data !== ed))) begin
                miscompares++;
                $display("FAIL back_to_back c=%0d: cr=%b wr=%b wait=%b err=%b addr=%h data=%h, want cr=1 wr=%b wait=%b err=%b addr=%h data=%h",
                         c, core_reset, dn_wr, wait_o, load_error, dn_addr, dn_data, exp_wr, exp_wait, c >= 3, ea, ed);
            end
        end
        @(posedge clk); #1 wr = 0; dl = 0;
        wait_run("b2b_return_run");
    endtask

    task automatic test_ignored();
        bit exp_wr;
        @(posedge clk); #1 dl = 1; idx = 8'd0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            wr = c == 0 || c == 4;
            addr = c == 0 ? 25'h4000 : 25'h3FFF;
            dout = 8'h5A;
            @(negedge clk);
            exp_wr = c == 5 || c == 6;
            vectors++;
            if (dn_wr !== exp_wr || (exp_wr && dn_addr !== 14'h3FFF)) begin
                miscompares++;
                $display("FAIL rom_bound c=%0d: wr=%b addr=%h, want wr=%b addr=3fff", c, dn_wr, dn_addr, exp_wr);
            end
        end
        @(posedge clk); #1 wr = 0; dl = 0;
        wait_run("bound_return_run");
        @(posedge clk); #1 dl = 1; idx = 8'd2;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            wr = c % 2 == 0 && c < 10;
            addr = 25'(c);
            dl = c < 10;
            if (c >= 10) idx = 8'd0;
            @(negedge clk);
            vectors++;
            if (core_reset !== 1'b0 || dn_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL ignored_dl c=%0d: cr=%b wr=%b, want 0 0", c, core_reset, dn_wr);
            end
        end
        @(posedge clk); #1 wr = 0;
    endtask

    task automatic test_user_reset();
        int last;
        bit exp_cr;
        for (int v = 0; v < 2; v++) begin
            last = v == 1 ? 5 : 0;
            for (int k = 0; k < RS + 12; k++) begin
                @(posedge clk); #1;
                user_reset = k == 0 || (v == 1 && k == 5);
                @(negedge clk);
                exp_cr = k >= 1 && k <= last + RS;
                vectors++;
                if (core_reset !== exp_cr) begin
                    miscompares++;
                    $display("FAIL user_reset v=%0d k=%0d: cr=%b, want %b", v, k, core_reset, exp_cr);
                end
            end
        end
        @(posedge clk); #1 user_reset = 0;
    endtask

    task automatic test_random_rom();
        localparam int L = 150;
        logic stb_a[L];
        logic [24:0] addr_a[L];
        logic [7:0] dat_a[L];
        pulse_t pq[$];
        int ws[$], we[$];
        int eng_end, buf_from, buf_start, s;
        bit err, exp_wr, exp_wait;
        logic [13:0] ea;
        logic [7:0] ed;
        do_reset();
        for (int c = 0; c < L; c++) begin
            stb_a[c] = c < L - 20 && $urandom_range(0, 2) == 0;
            addr_a[c] = $urandom_range(0, 7) == 0 ? 25'(ROM_SIZE + $urandom_range(0, 1000)) : 25'($urandom_range(0, ROM_SIZE - 1));
            dat_a[c] = 8'($urandom);
        end
        eng_end = -100; buf_from = -100; buf_start = -100; err = 0;
        for (int t = 0; t < L; t++) begin
            if (stb_a[t] && addr_a[t] < 25'(ROM_SIZE)) begin
                if (t >= buf_from && t < buf_start)
                    err = 1;
                else if (t > eng_end) begin
                    pq.push_back('{t + 1, addr_a[t][13:0], dat_a[t]});
                    eng_end = t + WR;
                end else begin
                    s = t < eng_end ? eng_end + 1 : t + 2;
                    pq.push_back('{s, addr_a[t][13:0], dat_a[t]});
                    buf_from = t + 1;
                    buf_start = s;
                    eng_end = s + WR - 1;
                    ws.push_back(t + 1);
                    we.push_back(s);
                end
            end
        end
        @(posedge clk); #1 dl = 1; idx = 8'd0;
        for (int c = 0; c < L + 5; c++) begin
            @(posedge clk); #1;
            wr = c < L ? stb_a[c] : 1'b0;
            addr = c < L ? addr_a[c] : 25'd0;
            dout = c < L ? dat_a[c] : 8'd0;
            @(negedge clk);
            exp_wr = 0; exp_wait = 0; ea = '0; ed = '0;
            foreach (pq[i])
                if (c >= pq[i].s && c < pq[i].s + WR) begin
                    exp_wr = 1; ea = pq[i].a; ed = pq[i].d;
                end
            foreach (ws[i])
                if (c >= ws[i] && c <= we[i]) exp_wait = 1;
            vectors++;
            if (dn_wr !== exp_wr || wait_o !== exp_wait || (exp_wr && (dn_addr !== ea || dn_data !== ed))) begin
                miscompares++;
                $display("FAIL random_rom c=%0d: wr=%b wait=%b addr=%h data=%h, want wr=%b wait=%b addr=%h data=%h",
                         c, dn_wr, wait_o, dn_addr, dn_data, exp_wr, exp_wait, ea, ed);
            end
        end
        vectors++;
        if (load_error !== err || rom_loaded !== (pq.size() > 0)) begin
            miscompares++;
            $display("FAIL random_flags: err=%b loaded=%b, want %b %b", load_error, rom_loaded, err, pq.size() > 0);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 dl = 1; idx = 8'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            wr = c <= 1;
            addr = 25'(10 + c);
            dout = 8'($urandom);
            reset = c == 2;
            @(negedge clk);
        end
        vectors++;
        if (dn_wr !== 1'b1 || wait_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_precond: wr=%b wait=%b, want 1 1", dn_wr, wait_o);
        end
        @(posedge clk); #1 reset = 0; wr = 0;
        @(negedge clk);
        vectors++;
        if (dn_wr !== 1'b0 || wait_o !== 1'b0 || rom_loaded !== 1'b0 || load_error !== 1'b0 || core_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: wr=%b wait=%b loaded=%b err=%b cr=%b, want 0 0 0 0 1", dn_wr, wait_o, rom_loaded, load_error, core_reset);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (dn_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_discard c=%0d: wr=%b, want 0", c, dn_wr);
            end
        end
        @(posedge clk); #1 dl = 0;
        for (int c = 0; c < RS + 6; c++) begin
            @(negedge clk);
            vectors++;
            if (core_reset !== 1'b1 || rom_loaded !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_to_boot c=%0d: cr=%b loaded=%b, want 1 0", c, core_reset, rom_loaded);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_rom_spaced();
        test_back_to_back();
        test_ignored();
        test_user_reset();
        test_random_rom();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/blockade_loader.md
Name: blockade_loader

Overview:
- Sequences the MiSTer ioctl download into the core's ROM write port and owns the core reset for the Blockade family core.
- Writes index-0 bytes to dn_addr/dn_data/dn_wr with a fixed write pulse width, throttling the HPS through ioctl_wait via a 1-deep skid buffer.
- Latches game_mode/overlay_type from an index-1 config download.
- Holds core_reset through boot, download and a reset stretch; replaces the ad-hoc rom_downloaded latch at the top level.

Parameters:
- ROM_SIZE, 16384: accepted index-0 address range, 0..ROM_SIZE-1.
- WR_CYCLES, 2: cycles dn_wr is held high per byte, minimum 1.
- RESET_STRETCH, 16: cycles core_reset stays high after download end or user_reset, minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- user_reset  in  1  OSD/button reset request, level
- ioctl_download  in  1  download active
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  0 = ROM, 1 = config, others ignored
- ioctl_wait  out  1  HPS stall
- dn_addr  out  14  ROM write address
- dn_data  out  8  ROM write data
- dn_wr  out  1  ROM write enable
- game_mode  out  2  latched mode
- overlay_type  out  2  latched overlay
- core_reset  out  1  reset to core
- rom_loaded  out  1  at least one ROM byte written since reset
- load_error  out  1  sticky: strobe dropped because buffer was full

Behaviour:
- All outputs registered. After reset:
  - core_reset = 1
  - ioctl_wait, dn_wr, rom_loaded, load_error = 0
  - dn_addr, dn_data, game_mode, overlay_type = 0
  - state = BOOT; buffer and engine empty.
- FSM states: BOOT, LOAD, DRAIN, HOLD, RUN. core_reset = 1 in every state except RUN.
- BOOT/RUN -> LOAD when ioctl_download=1 and ioctl_index is 0 or 1. core_reset rises the cycle after ioctl_download is first seen in RUN.
- Downloads with any other index are ignored; state does not change.
- LOAD -> DRAIN on ioctl_download=0.
- DRAIN -> HOLD once the engine is idle and the buffer is empty.
- HOLD loads a counter with RESET_STRETCH-1 and counts down.
  - At 0: -> RUN if rom_loaded, else -> BOOT.
- RUN -> HOLD on user_reset=1. user_reset asserted during HOLD reloads the counter.
- Write engine:
  - An index-0 ioctl_wr with ioctl_addr < ROM_SIZE at cycle t, engine idle: dn_addr = ioctl_addr[13:0] and dn_data = ioctl_dout valid from t+1; dn_wr high t+1..t+WR_CYCLES.
  - Address and data remain stable while dn_wr is high.
  - rom_loaded is set at t+1.
- Skid buffer:
  - A strobe arriving while the engine is busy goes to the buffer; ioctl_wait = 1 from the next cycle until the buffer drains.
  - The engine takes the buffer the cycle after the current pulse ends (no idle gap).
  - A strobe arriving while the buffer is full is dropped and load_error is set.
- Index-0 addresses >= ROM_SIZE are ignored silently.
- Config (index 1), on ioctl_wr:
  - addr 0: game_mode = ioctl_dout[1:0]
  - addr 1: overlay_type = ioctl_dout[1:0]
  - other addresses: ignored
  - Config bytes never use the engine, never stall and never set rom_loaded.
- A strobe with ioctl_download=0 is ignored.
- reset in any state (including mid-pulse) aborts the pulse and returns to BOOT. The buffered byte is discarded and rom_loaded/load_error are cleared.

Decomposition:
- blockade_pkg holds:
  - state enum: BOOT, LOAD, DRAIN, HOLD, RUN
  - IDX_ROM = 0, IDX_CFG = 1
  - CFG_ADDR_MODE = 0, CFG_ADDR_OVERLAY = 1
  - game-mode constants, shared with the core
- One natural sub-module, blockade_loader_wr: skid buffer, WR_CYCLES pulse counter and wait generation. The parent keeps the FSM, config latches and reset stretch.

Test Plan:
- Boot, no download, 100 cycles -> core_reset = 1, state BOOT, dn_wr never pulses.
- Config download: index 1, bytes {0x03 @0, 0x02 @1} -> game_mode = 3, overlay_type = 2. rom_loaded stays 0; after download end and HOLD, state returns to BOOT with core_reset = 1.
- ROM download, strobes spaced 4 cycles (WR_CYCLES = 2), addrs 0..3, data A0..A3 -> four dn_wr pulses, each 2 cycles wide, carrying the matching addr/data. ioctl_wait never asserts. After download end, core_reset falls exactly RESET_STRETCH cycles after DRAIN completes.
- Back-to-back strobes at t and t+1 (addr 5, 6) -> pulses at t+1..t+2 (addr 5) and t+3..t+4 (addr 6); ioctl_wait high t+2..t+3. A third strobe at t+2 is dropped and load_error = 1.
- Index-0 write to addr 0x4000 with ROM_SIZE = 16384 -> no dn_wr. Index-2 download while in RUN -> core_reset stays 0.
- Reset mid-pulse (engine busy, buffer full) -> next cycle dn_wr = 0, ioctl_wait = 0, rom_loaded = 0, state BOOT. user_reset pulse in RUN -> core_reset high for RESET_STRETCH cycles, then back to RUN.
